ifu_pc_seq: RTL and testbench
=============================

Name: ifu_pc_seq

Overview:
- Fetch sequencer that owns the program counter and drives the instruction-memory request/response handshake.
- Selects the next PC: sequential +4, EXU branch/jump redirect, or trap vector.
- Hands fetched instructions to the IDU over a valid/ready interface.
- Handles redirects arriving while a fetch is outstanding by squashing the wrong-path response.

Parameters:
- WIDTH, 32, PC/address width (matches `RegWidth).
- RESET_PC, 32'h8000_0000, PC value after reset (matches `PcRst).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  EXU taken branch/jump this cycle.
- redirect_pc  in  WIDTH  branch/jump target.
- trap_valid  in  1  trap/mret this cycle; has priority over redirect_valid.
- trap_pc  in  WIDTH  mtvec/mepc target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  WIDTH  fetch address.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  response data valid (exactly one per accepted request).
- imem_rsp_data  in  32  fetched instruction.
- inst_valid  out  1  instruction available to the IDU.
- inst_data  out  32  instruction.
- inst_pc  out  WIDTH  PC of inst_data.
- inst_ready  in  1  IDU accepts the instruction.
- current_pc  out  WIDTH  PC register value.
- misalign_err  out  1  one-cycle pulse on a misaligned target (feature only).

Behaviour:
- States: IDLE, REQ, WAIT, HOLD. Reset state is IDLE.
- Reset values: pc=RESET_PC, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, misalign_err=0, kill=0.
- Target selection: tgt = trap_pc if trap_valid, else redirect_pc. Define flush = trap_valid | redirect_valid.
- IDLE:
  - Always moves to REQ next cycle.
  - On flush, pc<=tgt.
- REQ:
  - imem_req_valid=1 and imem_req_addr=pc.
  - Address is held stable until imem_req_ready.
  - When ready: go to WAIT.
  - On flush in REQ (with or without ready): pc<=tgt and kill<=1. The address already presented is not changed.
- WAIT:
  - On imem_rsp_valid with kill=0 and no flush that cycle: inst_data<=imem_rsp_data, inst_pc<=pc; go to HOLD.
  - On imem_rsp_valid with kill=1 or flush that cycle: discard the response. kill<=0; on flush, pc<=tgt; go to REQ.
  - On flush without rsp: pc<=tgt and kill<=1.
- HOLD:
  - inst_valid = 1 & ~flush. This is combinational suppression: no transfer occurs in a flush cycle.
  - On handshake: pc<=pc+4 (mod 2^WIDTH), go to REQ.
  - On flush: drop the held instruction, pc<=tgt, go to REQ.
  - inst_data and inst_pc stay stable while inst_valid=1 and inst_ready=0.
- Latency: after reset deassertion, cycle 0 is IDLE and cycle 1 is REQ at RESET_PC. With req accepted in cycle N and rsp in N+k, inst_valid is asserted in N+k+1.
- Steady-state throughput: one instruction per 3 cycles with a 1-cycle memory (non-pipelined, one request outstanding).
- Back-to-back flushes: the latest one wins. kill is a single bit because at most one request is outstanding.
- current_pc always shows the pc register.
- Asynchronous reset mid-fetch returns to IDLE with reset values. A response arriving after reset release while in IDLE/REQ is ignored.

Optional Feature:
- Macro: PC_MISALIGN_CHK_EN.
- Defined:
  - If tgt[1:0]!=0 in a flush cycle, misalign_err pulses for 1 cycle.
  - pc is loaded with tgt unchanged; the flush otherwise proceeds normally.
- Undefined:
  - pc is loaded with {tgt[WIDTH-1:2],2'b00}.
  - misalign_err is tied to 0.

Test Plan:
1. Reset release, memory ready=1 with 1-cycle rsp, inst_ready=1 -> imem_req_addr sequence 0x80000000, 0x80000004, 0x80000008; inst_pc matches; one instruction per 3 cycles.
2. inst_ready=0 for 5 cycles in HOLD -> inst_valid stays 1, inst_data/inst_pc stable; no new imem request until the handshake.
3. redirect_valid with redirect_pc=0x80000100 while in WAIT -> the following rsp is discarded (inst_valid never asserts for it); next request at 0x80000100.
4. trap_valid (trap_pc=0x80000400) and redirect_valid (0x80000100) in the same cycle in HOLD -> inst_valid=0 that cycle; next request at 0x80000400.
5. Flush in REQ while imem_req_ready=0 for 3 cycles -> imem_req_addr unchanged until accept; response squashed; next request at the new target.
6. pc=0xFFFFFFFC with inst handshake -> next request at 0x00000000. Redirect to 0x80000102 -> with PC_MISALIGN_CHK_EN: misalign_err pulse and address 0x80000102; without it: address 0x80000100 and misalign_err=0.

Source files
------------

// File: rtl/ifu_pc_seq.sv
// Fetch sequencer: owns the PC, runs one-outstanding imem fetches and hands instructions to the IDU.
// Define PC_MISALIGN_CHK_EN to keep misaligned flush targets and pulse misalign_err instead of aligning them.
module ifu_pc_seq #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             trap_valid,
    input  logic [WIDTH-1:0] trap_pc,
    output logic             imem_req_valid,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             inst_valid,
    output logic [31:0]      inst_data,
    output logic [WIDTH-1:0] inst_pc,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] current_pc,
    output logic             misalign_err
);

    localparam int unsigned INST_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [WIDTH-1:0]  addr_q, addr_d;
    logic              req_valid_q, req_valid_d;
    logic [INST_W-1:0] inst_data_q, inst_data_d;
    logic [WIDTH-1:0]  inst_pc_q, inst_pc_d;
    logic              kill_q, kill_d;
    logic              misalign_q, misalign_d;

    logic              flush;
    logic [WIDTH-1:0]  tgt_raw;
    logic [WIDTH-1:0]  tgt;
    logic              mis_c;

    // Trap wins over a same-cycle branch redirect
    assign flush   = trap_valid | redirect_valid;
    assign tgt_raw = trap_valid ? trap_pc : redirect_pc;

`ifdef PC_MISALIGN_CHK_EN
    assign tgt   = tgt_raw;
    assign mis_c = flush & (tgt_raw[1:0] != 2'b00);
`else
    assign tgt   = tgt_raw & ~WIDTH'(3);
    assign mis_c = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;
        kill_d      = kill_q;
        misalign_d  = mis_c;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (flush) pc_d = tgt;
            end
            ST_REQ: begin
                // Presented address stays put; the eventual response is marked wrong-path
                if (flush) begin
                    pc_d   = tgt;
                    kill_d = 1'b1;
                end
                if (imem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q || flush) begin
                        kill_d  = 1'b0;
                        if (flush) pc_d = tgt;
                        state_d = ST_REQ;
                    end else begin
                        inst_data_d = imem_rsp_data;
                        inst_pc_d   = pc_q;
                        state_d     = ST_HOLD;
                    end
                end else if (flush) begin
                    pc_d   = tgt;
                    kill_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    pc_d    = tgt;
                    state_d = ST_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + WIDTH'(4);
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_valid_d = (state_d == ST_REQ);
        // Latch the fetch address only on entry to REQ so it is stable until accepted
        if ((state_d == ST_REQ) && (state_q != ST_REQ)) addr_d = pc_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            req_valid_q <= 1'b0;
            inst_data_q <= '0;
            inst_pc_q   <= '0;
            kill_q      <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            req_valid_q <= req_valid_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
            kill_q      <= kill_d;
            misalign_q  <= misalign_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = addr_q;
    // Held instruction is hidden in a flush cycle so no transfer can complete
    assign inst_valid     = (state_q == ST_HOLD) & ~flush;
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;
    assign current_pc     = pc_q;
    assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_ifu_pc_seq.sv
// Bench for ifu_pc_seq: cycle table after reset, scoreboard of delivered instructions, directed corner sequences.
// Expectations follow PC_MISALIGN_CHK_EN the same way the design does.
module tb_ifu_pc_seq;

    localparam int unsigned W      = 32;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic          clk;
    logic          rst;
    logic          redirect_valid;
    logic [W-1:0]  redirect_pc;
    logic          trap_valid;
    logic [W-1:0]  trap_pc;
    logic          imem_req_valid;
    logic [W-1:0]  imem_req_addr;
    logic          imem_req_ready;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          inst_valid;
    logic [31:0]   inst_data;
    logic [W-1:0]  inst_pc;
    logic          inst_ready;
    logic [W-1:0]  current_pc;
    logic          misalign_err;

    ifu_pc_seq #(.WIDTH(W), .RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .trap_valid    (trap_valid),
        .trap_pc       (trap_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .current_pc    (current_pc),
        .misalign_err  (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        iv;
        logic [31:0] ipc;
        logic [31:0] cpc;
    } vec_t;

    vec_t        tbl [10];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];

    logic        s_rv, s_iv, s_mis, s_xfer;
    logic [31:0] s_ra, s_ipc, s_idata, s_cpc;

    int          mem_lat = 1;
    logic        m_pend  = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_addr  = 32'h0;

    logic [31:0] hp, hd, a0;

`ifdef PC_MISALIGN_CHK_EN
    localparam logic MIS_EXP = 1'b1;
`else
    localparam logic MIS_EXP = 1'b0;
`endif

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] exp_tgt(input logic [31:0] t);
`ifdef PC_MISALIGN_CHK_EN
        return t;
`else
        return t & 32'hFFFF_FFFC;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    // One clock: sample at negedge, score transfers, then drive memory response after posedge
    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        s_rv    = imem_req_valid;
        s_ra    = imem_req_addr;
        s_iv    = inst_valid;
        s_ipc   = inst_pc;
        s_idata = inst_data;
        s_cpc   = current_pc;
        s_mis   = misalign_err;
        s_xfer  = inst_valid & inst_ready;
        if (trap_valid || redirect_valid) begin
            chk("valid_in_flush", 32'(inst_valid), 32'h0);
            exp_q.delete();
            exp_q.push_back(exp_tgt(trap_valid ? trap_pc : redirect_pc));
        end else if (s_xfer) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got pc %h expected no transfer", inst_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", inst_pc, e);
                chk("sb_data", inst_data, mem_f(e));
                exp_q.push_back(e + 32'd4);
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            m_pend = 1'b1;
            m_cnt  = mem_lat;
            m_addr = imem_req_addr;
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (m_pend) begin
            m_cnt--;
            if (m_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_f(m_addr);
                m_pend         = 1'b0;
            end
        end
    endtask

    task automatic wait_req(input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            hit = s_rv;
        end
        if (!hit) fail_now(nm);
    endtask

    task automatic wait_hold(input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            hit = s_iv;
        end
        if (!hit) fail_now(nm);
    endtask

    task automatic wait_xfer(input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            hit = s_xfer;
        end
        if (!hit) fail_now(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rv, ra, iv, ipc, cpc per cycle after reset release (1-cycle memory, IDU always ready)
        tbl[0] = '{1'b0, 32'h0,          1'b0, 32'h0,          32'h8000_0000};
        tbl[1] = '{1'b1, 32'h8000_0000,  1'b0, 32'h0,          32'h8000_0000};
        tbl[2] = '{1'b0, 32'h0,          1'b0, 32'h0,          32'h8000_0000};
        tbl[3] = '{1'b0, 32'h0,          1'b1, 32'h8000_0000,  32'h8000_0000};
        tbl[4] = '{1'b1, 32'h8000_0004,  1'b0, 32'h0,          32'h8000_0004};
        tbl[5] = '{1'b0, 32'h0,          1'b0, 32'h0,          32'h8000_0004};
        tbl[6] = '{1'b0, 32'h0,          1'b1, 32'h8000_0004,  32'h8000_0004};
        tbl[7] = '{1'b1, 32'h8000_0008,  1'b0, 32'h0,          32'h8000_0008};
        tbl[8] = '{1'b0, 32'h0,          1'b0, 32'h0,          32'h8000_0008};
        tbl[9] = '{1'b0, 32'h0,          1'b1, 32'h8000_0008,  32'h8000_0008};

        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        trap_valid     = 1'b0;
        trap_pc        = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b1;
        exp_q.push_back(RST_PC);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_cur_pc", current_pc, RST_PC);
        chk("rst_misalign", 32'(misalign_err), 32'h0);
        rst = 1'b1;

        // Sequential fetch, one instruction every 3 cycles
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t1_rv[%0d]", i), 32'(s_rv), 32'(tbl[i].rv));
            if (tbl[i].rv) chk($sformatf("t1_ra[%0d]", i), s_ra, tbl[i].ra);
            chk($sformatf("t1_iv[%0d]", i), 32'(s_iv), 32'(tbl[i].iv));
            if (tbl[i].iv) chk($sformatf("t1_ipc[%0d]", i), s_ipc, tbl[i].ipc);
            chk($sformatf("t1_cpc[%0d]", i), s_cpc, tbl[i].cpc);
        end

        // IDU stall in HOLD
        inst_ready = 1'b0;
        wait_hold("t2_hold");
        hp = s_ipc;
        hd = s_idata;
        chk("t2_hold_pc", hp, 32'h8000_000C);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_iv", 32'(s_iv), 32'h1);
            chk("t2_ipc", s_ipc, hp);
            chk("t2_idata", s_idata, hd);
            chk("t2_no_req", 32'(s_rv), 32'h0);
        end
        inst_ready = 1'b1;
        step();
        chk("t2_xfer", 32'(s_xfer), 32'h1);
        step();
        chk("t2_next_rv", 32'(s_rv), 32'h1);
        chk("t2_next_ra", s_ra, 32'h8000_0010);
        wait_xfer("t2_x");

        // Redirect while WAIT with no response yet: late response must be squashed
        mem_lat = 2;
        wait_req("t3_req");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        step();
        chk("t3_squash_iv", 32'(s_iv), 32'h0);
        chk("t3_squash_rv", 32'(s_rv), 32'h0);
        step();
        chk("t3_rv", 32'(s_rv), 32'h1);
        chk("t3_ra", s_ra, 32'h8000_0100);
        wait_xfer("t3_x");

        // Trap and redirect together in HOLD: trap wins, no transfer that cycle
        mem_lat    = 1;
        inst_ready = 1'b0;
        wait_hold("t4_hold");
        trap_valid     = 1'b1;
        trap_pc        = 32'h8000_0400;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        inst_ready     = 1'b1;
        step();
        trap_valid     = 1'b0;
        redirect_valid = 1'b0;
        chk("t4_iv", 32'(s_iv), 32'h0);
        step();
        chk("t4_rv", 32'(s_rv), 32'h1);
        chk("t4_ra", s_ra, 32'h8000_0400);
        wait_xfer("t4_x");

        // Flush in REQ while memory is not ready
        imem_req_ready = 1'b0;
        wait_req("t5_req");
        a0 = s_ra;
        chk("t5_a0", a0, 32'h8000_0404);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step();
        redirect_valid = 1'b0;
        chk("t5_ra_c2", s_ra, a0);
        step();
        chk("t5_rv_c3", 32'(s_rv), 32'h1);
        chk("t5_ra_c3", s_ra, a0);
        imem_req_ready = 1'b1;
        step();
        chk("t5_ra_acc", s_ra, a0);
        step();
        chk("t5_squash_iv", 32'(s_iv), 32'h0);
        step();
        chk("t5_rv", 32'(s_rv), 32'h1);
        chk("t5_ra", s_ra, 32'h8000_0200);
        wait_xfer("t5_x");

        // PC wrap, then misaligned redirect
        inst_ready = 1'b0;
        wait_hold("t6_h");
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        inst_ready     = 1'b1;
        step();
        redirect_valid = 1'b0;
        wait_req("t6_r");
        chk("t6_ra_top", s_ra, 32'hFFFF_FFFC);
        wait_xfer("t6_x");
        wait_req("t6_wrap");
        chk("t6_ra_wrap", s_ra, 32'h0000_0000);
        inst_ready = 1'b0;
        wait_hold("t6_h2");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        chk("t6_mis_pre", 32'(s_mis), 32'h0);
        step();
        chk("t6_mis", 32'(s_mis), 32'(MIS_EXP));
        chk("t6_mis_rv", 32'(s_rv), 32'h1);
        chk("t6_mis_ra", s_ra, MIS_EXP ? 32'h8000_0102 : 32'h8000_0100);
        step();
        chk("t6_mis_post", 32'(s_mis), 32'h0);
        inst_ready = 1'b1;
        wait_xfer("t6_x2");

        // Async reset mid-fetch; the stale response lands in REQ and is ignored
        mem_lat = 2;
        wait_req("t7_req");
        rst = 1'b0;
        #1;
        chk("t7_rst_rv", 32'(imem_req_valid), 32'h0);
        chk("t7_rst_iv", 32'(inst_valid), 32'h0);
        chk("t7_rst_cpc", current_pc, RST_PC);
        chk("t7_rst_ipc", inst_pc, 32'h0);
        exp_q.delete();
        exp_q.push_back(RST_PC);
        rst = 1'b1;
        step();
        chk("t7_idle_rv", 32'(s_rv), 32'h0);
        step();
        chk("t7_req_rv", 32'(s_rv), 32'h1);
        chk("t7_req_ra", s_ra, RST_PC);
        chk("t7_req_iv", 32'(s_iv), 32'h0);
        wait_xfer("t7_x");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
